// File: rtl/imem_loader_pkg.sv
// Package: imem_loader_pkg
// Purpose: shared definitions for the instruction-memory loader slice.
//   - state_t: loader FSM encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3)
//   - DEF_WIDTH / DEF_WORD_LENGTH: default word width and memory depth
//   - bytes_per_word(): bytes packed into one instruction word (BPW)
//   - addr_width(): memory address width (AW) for a given depth
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_WORD_LENGTH = 32;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

  // A one-word memory still needs a one-bit address port, so the
  // width is never allowed to collapse to zero.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// Module: word_assembler
// Purpose: packs a stream of bytes big-endian into one width-bit word.
//   The first byte of a word ends up in the most significant byte.
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous active-high reset
//   shift_en   in   1      a byte is being transferred this cycle
//   clear      in   1      discard any partial word
//   byte_data  in   8      byte to shift in
//   word       out  width  assembled word (complete during the cycle after full)
//   full       out  1      the byte transferred this cycle completes the word
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [7:0]       byte_data,
  output logic [width-1:0] word,
  output logic             full
);

  localparam int BPW = bytes_per_word(width);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [CW-1:0] count;

  // The word is complete on the same cycle its last byte is transferred, so
  // the loader can move to its write state on that edge without a bubble.
  assign full = shift_en && (count == LAST);

  // Shift register and byte counter. Truncating {word, byte} to width bits
  // drops the oldest byte off the top, which keeps the first byte of a word
  // in the MSBs once all BPW bytes have arrived. The counter wraps back to
  // zero on the completing byte so the next word starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      word  <= '0;
    end else if (shift_en) begin
      word  <= width'({word, byte_data});
      count <= full ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Module: imem_loader
// Purpose: writer side of the instruction-memory interface. Streams bytes from a
//   host valid/ready link, packs them big-endian into width-bit words and writes
//   them to consecutive memory addresses starting at 0. Keeps the processor in
//   reset (cpu_rst=1) until a complete image has been written.
// Ports:
//   clk         in   1      system clock
//   rst         in   1      synchronous active-high reset
//   start       in   1      begin a load (honoured in IDLE and DONE only)
//   load_len    in   AW+1   words to load, sampled with start, clamped to depth
//   byte_valid  in   1      host byte available
//   byte_data   in   8      host byte
//   byte_ready  out  1      loader accepts a byte this cycle
//   wr_en       out  1      memory write strobe, one cycle per word
//   wr_addr     out  AW     memory write address
//   wr_data     out  width  memory write word
//   cpu_rst     out  1      processor reset hold
//   busy        out  1      load in progress
//   done        out  1      last load completed (sticky)
//   words_done  out  AW+1   words written in the current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int width      = DEF_WIDTH,
  parameter  int wordLength = DEF_WORD_LENGTH,
  localparam int AW         = addr_width(wordLength)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW:0]      load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [width-1:0] wr_data,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      words_done
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(wordLength);

  state_t             state;
  state_t             next_state;
  logic [AW:0]        len_q;
  logic [AW:0]        clamped_len;
  logic [AW:0]        words_next;
  logic [AW-1:0]      addr_hold;
  logic [width-1:0]   data_hold;
  logic [width-1:0]   asm_word;
  logic               asm_full;
  logic               asm_clear;
  logic               load_start;
  logic               shift_en;

  // A request longer than the memory is trimmed to the memory depth, which is
  // what guarantees the write address can never run past the last word.
  assign clamped_len = (load_len > DEPTH) ? DEPTH : load_len;
  assign words_next  = words_done + (AW + 1)'(1);
  assign shift_en    = (state == COLLECT) && byte_valid;

  word_assembler #(
    .width(width)
  ) u_assembler (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (asm_clear),
    .byte_data(byte_data),
    .word     (asm_word),
    .full     (asm_full)
  );

  // Next-state logic. A new load can only begin from IDLE or DONE; start is
  // deliberately ignored while bytes are being collected or written so a stray
  // pulse cannot corrupt an image in progress. A zero-length load goes straight
  // to DONE, which releases the processor without touching memory.
  always_comb begin
    next_state = state;
    asm_clear  = 1'b0;
    load_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_start = 1'b1;
          asm_clear  = 1'b1;
          next_state = (clamped_len == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (asm_full) next_state = WRITE;
      end
      WRITE: begin
        next_state = (words_next == len_q) ? DONE : COLLECT;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus the length/progress counters. The address and data
  // of each write are also copied into hold registers during WRITE so the
  // memory port keeps showing the last word written once the strobe drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      words_done <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
    end else begin
      state <= next_state;
      if (load_start) begin
        len_q      <= clamped_len;
        words_done <= '0;
      end
      if (state == WRITE) begin
        words_done <= words_next;
        addr_hold  <= words_done[AW-1:0];
        data_hold  <= asm_word;
      end
    end
  end

  // Moore outputs decoded from the registered state. The processor is held in
  // reset everywhere except DONE so it never fetches from a partial image.
  always_comb begin
    byte_ready = (state == COLLECT);
    wr_en      = (state == WRITE);
    busy       = (state == COLLECT) || (state == WRITE);
    done       = (state == DONE);
    cpu_rst    = (state != DONE);
    wr_addr    = (state == WRITE) ? words_done[AW-1:0] : addr_hold;
    wr_data    = (state == WRITE) ? asm_word : data_hold;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench: tb_imem_loader
// Purpose: randomized and directed checks of imem_loader against a byte-list
//   reference model: the expected image is simply consecutive groups of four
//   host bytes, most significant first, for min(load_len, depth) words.
module tb_imem_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic [AW:0]   words_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  src[$];
  int          cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;
  int          ready_in_write = 0;
  int          collect_not_ready = 0;

  imem_loader #(
    .width(32),
    .wordLength(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .words_done(words_done)
  );

  // Free-running clock and a cycle counter used to measure write/done latency.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor on the falling edge: records every write strobe and the
  // cycle on which done rises, and counts handshake-rule violations.
  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr.push_back(int'(wr_addr));
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
    if (wr_en && byte_ready) ready_in_write++;
    if (busy && !wr_en && !byte_ready) collect_not_ready++;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: word w of the image is host bytes 4w..4w+3, first byte highest.
  function automatic logic [31:0] expected_word(input int w);
    return (32'(src[4*w]) << 24) | (32'(src[4*w+1]) << 16) |
           (32'(src[4*w+2]) << 8) | 32'(src[4*w+3]);
  endfunction

  function automatic int expected_count(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
    cap_cyc.delete();
    done_rise_cyc = -1;
  endtask

  task automatic fill_random(input int nbytes);
    src.delete();
    for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    start    = 1'b1;
    load_len = (AW + 1)'(len);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic pulse_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    start      = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b0;
  endtask

  // Host side of the byte link. mode 0: valid always high, 1: toggles each
  // cycle, 2: random. A byte counts as taken only when valid and ready meet.
  task automatic feed(input int first, input int count, input int mode,
                      output int last_cyc, output bit ok);
    int  idx   = first;
    int  guard = 0;
    bit  phase = 1'b1;
    bit  v;
    bit  xfer;
    last_cyc = -1;
    while (idx < first + count && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase      = !phase;
      byte_valid = v;
      byte_data  = v ? src[idx] : 8'($urandom);
      xfer       = v && byte_ready;
      @(posedge clk); #1;
      if (xfer) begin
        idx++;
        last_cyc = cyc;
      end
      guard++;
    end
    byte_valid = 1'b0;
    ok = (idx == first + count);
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!done && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cpu_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    vectors++;
    if (byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_byte_ready: got %b expected 0", byte_ready); end
    vectors++;
    if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++;
    if (words_done !== '0) begin miscompares++; $display("[TB] FAIL reset_words_done: got %0d expected 0", words_done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic(input int mode, input string tag);
    int last;
    bit ok_feed;
    bit ok_done;
    src = {8'h8C, 8'h22, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08};
    clear_capture();
    pulse_start(2);
    feed(0, 8, mode, last, ok_feed);
    wait_done(ok_done);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (!(ok_feed && ok_done)) begin miscompares++; $display("[TB] FAIL %s_handshake: feed=%b done=%b expected both 1", tag, ok_feed, ok_done); end
    vectors++;
    if (cap_addr.size() !== 2) begin miscompares++; $display("[TB] FAIL %s_write_count: got %0d expected 2", tag, cap_addr.size()); end
    for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
      vectors++;
      if (cap_addr[i] !== i) begin miscompares++; $display("[TB] FAIL %s_addr%0d: got %0d expected %0d", tag, i, cap_addr[i], i); end
      vectors++;
      if (cap_data[i] !== expected_word(i)) begin miscompares++; $display("[TB] FAIL %s_data%0d: got %h expected %h", tag, i, cap_data[i], expected_word(i)); end
    end
    if (cap_cyc.size() == 2) begin
      vectors++;
      if (cap_cyc[1] !== last) begin miscompares++; $display("[TB] FAIL %s_wr_latency: got cycle %0d expected %0d", tag, cap_cyc[1], last); end
    end
    vectors++;
    if (done_rise_cyc !== last + 1) begin miscompares++; $display("[TB] FAIL %s_done_latency: got cycle %0d expected %0d", tag, done_rise_cyc, last + 1); end
    vectors++;
    if (cpu_rst !== 1'b0 || done !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_release: cpu_rst=%b done=%b expected 0/1", tag, cpu_rst, done); end
    vectors++;
    if (words_done !== 2) begin miscompares++; $display("[TB] FAIL %s_words_done: got %0d expected 2", tag, words_done); end
    vectors++;
    if (ready_in_write !== 0 || collect_not_ready !== 0) begin miscompares++; $display("[TB] FAIL %s_ready_rule: ready_in_write=%0d collect_not_ready=%0d expected 0/0", tag, ready_in_write, collect_not_ready); end
  endtask

  task automatic test_len_bounds();
    int last;
    bit ok_feed;
    bit ok_done;
    int n;
    pulse_reset();
    clear_capture();
    pulse_start(0);
    vectors++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_done: done=%b cpu_rst=%b expected 1/0", done, cpu_rst); end
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (cap_addr.size() !== 0) begin miscompares++; $display("[TB] FAIL len0_writes: got %0d expected 0", cap_addr.size()); end
    fill_random(4 * DEPTH);
    clear_capture();
    pulse_start(40);
    feed(0, 4 * DEPTH, 0, last, ok_feed);
    wait_done(ok_done);
    repeat (3) @(posedge clk); #1;
    n = expected_count(40);
    vectors++;
    if (!(ok_feed && ok_done)) begin miscompares++; $display("[TB] FAIL len40_handshake: feed=%b done=%b expected both 1", ok_feed, ok_done); end
    vectors++;
    if (cap_addr.size() !== n) begin miscompares++; $display("[TB] FAIL len40_write_count: got %0d expected %0d", cap_addr.size(), n); end
    for (int i = 0; i < n && i < cap_addr.size(); i++) begin
      vectors++;
      if (cap_addr[i] !== i || cap_data[i] !== expected_word(i)) begin
        miscompares++;
        $display("[TB] FAIL len40_word%0d: got addr %0d data %h expected addr %0d data %h", i, cap_addr[i], cap_data[i], i, expected_word(i));
      end
    end
    vectors++;
    if (words_done !== 32) begin miscompares++; $display("[TB] FAIL len40_words_done: got %0d expected 32", words_done); end
    vectors++;
    if (wr_addr !== 5'd31) begin miscompares++; $display("[TB] FAIL len40_last_addr_hold: got %0d expected 31", wr_addr); end
  endtask

  task automatic test_reset_midload();
    int last;
    bit ok_feed;
    bit ok_done;
    fill_random(8);
    clear_capture();
    pulse_start(2);
    feed(0, 7, 0, last, ok_feed);
    pulse_reset();
    vectors++;
    if (busy !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || words_done !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: busy=%b cpu_rst=%b done=%b words_done=%0d expected 0/1/0/0", busy, cpu_rst, done, words_done);
    end
    repeat (4) @(posedge clk); #1;
    vectors++;
    if (cap_addr.size() !== 1) begin miscompares++; $display("[TB] FAIL midrst_writes: got %0d expected 1", cap_addr.size()); end
    src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_capture();
    pulse_start(1);
    feed(0, 4, 0, last, ok_feed);
    wait_done(ok_done);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (cap_addr.size() !== 1) begin miscompares++; $display("[TB] FAIL midrst_reload_count: got %0d expected 1", cap_addr.size()); end
    else begin
      vectors++;
      if (cap_addr[0] !== 0 || cap_data[0] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("[TB] FAIL midrst_reload_word: got addr %0d data %h expected addr 0 data deadbeef", cap_addr[0], cap_data[0]);
      end
    end
  endtask

  task automatic test_restart();
    int last;
    bit ok_feed;
    bit ok_done;
    fill_random(4);
    clear_capture();
    pulse_start(1);
    vectors++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || words_done !== '0) begin
      miscompares++;
      $display("[TB] FAIL restart_state: cpu_rst=%b done=%b busy=%b words_done=%0d expected 1/0/1/0", cpu_rst, done, busy, words_done);
    end
    feed(0, 2, 0, last, ok_feed);
    pulse_start(9);
    vectors++;
    if (busy !== 1'b1 || words_done !== '0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_ignored_start: busy=%b words_done=%0d done=%b expected 1/0/0", busy, words_done, done);
    end
    feed(2, 2, 0, last, ok_feed);
    wait_done(ok_done);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (!ok_done || cap_addr.size() !== 1 || words_done !== 1) begin
      miscompares++;
      $display("[TB] FAIL restart_result: done=%b writes=%0d words_done=%0d expected 1/1/1", ok_done, cap_addr.size(), words_done);
    end
    if (cap_data.size() == 1) begin
      vectors++;
      if (cap_data[0] !== expected_word(0)) begin miscompares++; $display("[TB] FAIL restart_data: got %h expected %h", cap_data[0], expected_word(0)); end
    end
  endtask

  task automatic test_random();
    int last;
    bit ok_feed;
    bit ok_done;
    int len;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 5);
      fill_random(4 * len);
      clear_capture();
      pulse_start(len);
      feed(0, 4 * len, 2, last, ok_feed);
      wait_done(ok_done);
      repeat (2) @(posedge clk); #1;
      vectors++;
      if (!(ok_feed && ok_done) || cap_addr.size() !== len || words_done !== len || cpu_rst !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_summary: feed=%b done=%b writes=%0d words_done=%0d cpu_rst=%b expected 1/1/%0d/%0d/0",
                 t, ok_feed, ok_done, cap_addr.size(), words_done, cpu_rst, len, len);
      end
      for (int i = 0; i < len && i < cap_addr.size(); i++) begin
        vectors++;
        if (cap_addr[i] !== i || cap_data[i] !== expected_word(i)) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_word%0d: got addr %0d data %h expected addr %0d data %h", t, i, cap_addr[i], cap_data[i], i, expected_word(i));
        end
      end
    end
    vectors++;
    if (ready_in_write !== 0 || collect_not_ready !== 0) begin
      miscompares++;
      $display("[TB] FAIL rand_ready_rule: ready_in_write=%0d collect_not_ready=%0d expected 0/0", ready_in_write, collect_not_ready);
    end
  endtask

  initial begin
    $display("[TB] imem_loader bench starting");
    test_reset();
    test_basic(0, "back_to_back");
    test_basic(1, "toggle_valid");
    test_len_bounds();
    test_reset_midload();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
